// File: rtl/snitch_icache_lookup_arbiter_pkg.sv
// Shared types for the icache lookup arbiter: flush sequencer states,
// default lookup request/response layouts and the port-index width helper.
package snitch_icache_lookup_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } flush_state_e;

   typedef struct packed {
      int unsigned nr_ports;
      int unsigned fetch_aw;
      int unsigned id_width;
      int unsigned line_width;
      int unsigned set_align;
      int unsigned max_outstanding;
   } config_t;

   localparam int unsigned DEF_FETCH_AW   = 32;
   localparam int unsigned DEF_LKP_ID_W   = 5;
   localparam int unsigned DEF_LINE_WIDTH = 128;
   localparam int unsigned DEF_SET_ALIGN  = 1;

   typedef struct packed {
      logic [DEF_FETCH_AW-1:0] addr;
      logic [DEF_LKP_ID_W-1:0] id;
   } lkp_req_t;

   typedef struct packed {
      logic [DEF_FETCH_AW-1:0]   addr;
      logic [DEF_LKP_ID_W-1:0]   id;
      logic [DEF_SET_ALIGN-1:0]  set;
      logic                      hit;
      logic [DEF_LINE_WIDTH-1:0] data;
      logic                      error;
   } lkp_rsp_t;

   // A single requester still carries one index bit so the ID layout never collapses.
   function automatic int unsigned port_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/snitch_icache_lookup_arbiter_if.sv
// Lookup-side bus: request, response and flush handshakes towards the shared
// tag/data lookup stage.
interface snitch_icache_lookup_arbiter_if #(
   parameter int unsigned FETCH_AW   = 32,
   parameter int unsigned LKP_ID_W   = 5,
   parameter int unsigned LINE_WIDTH = 128,
   parameter int unsigned SET_ALIGN  = 1
) ();
   logic [FETCH_AW-1:0]   addr;
   logic [LKP_ID_W-1:0]   id;
   logic                  valid;
   logic                  ready;
   logic [FETCH_AW-1:0]   rsp_addr;
   logic [LKP_ID_W-1:0]   rsp_id;
   logic [SET_ALIGN-1:0]  rsp_set;
   logic                  rsp_hit;
   logic [LINE_WIDTH-1:0] rsp_data;
   logic                  rsp_error;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic                  flush_valid;
   logic                  flush_ready;

   modport master (
      output addr, id, valid, rsp_ready, flush_valid,
      input  ready, rsp_addr, rsp_id, rsp_set, rsp_hit, rsp_data, rsp_error, rsp_valid,
             flush_ready
   );

   modport slave (
      input  addr, id, valid, rsp_ready, flush_valid,
      output ready, rsp_addr, rsp_id, rsp_set, rsp_hit, rsp_data, rsp_error, rsp_valid,
             flush_ready
   );
endinterface

// File: rtl/snitch_icache_lookup_arbiter_chk.sv
// Protocol checks on the lookup response stream seen by the arbiter.
module snitch_icache_lookup_arbiter_chk #(
   parameter int unsigned NR_PORTS = 2,
   parameter int unsigned PORT_W   = 1
) (
   input logic              clk_i,
   input logic              rst_ni,
   input logic              rsp_hs_i,
   input logic              cnt_zero_i,
   input logic              rsp_valid_i,
   input logic [PORT_W-1:0] rsp_port_i
);
   a_rsp_without_outstanding: assert property (
      @(posedge clk_i) disable iff (!rst_ni) rsp_hs_i |-> !cnt_zero_i);

   a_rsp_port_in_range: assert property (
      @(posedge clk_i) disable iff (!rst_ni) rsp_valid_i |-> (int'(rsp_port_i) < NR_PORTS));
endmodule

// File: rtl/snitch_icache_lookup_arbiter_rr.sv
// Round-robin arbiter with lock-in: a presented but unaccepted grant is held
// until its handshake; the priority pointer only advances on acceptance.
module snitch_icache_lookup_arbiter_rr #(
   parameter int unsigned NR_PORTS = 2,
   parameter int unsigned PORT_W   = 1
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [NR_PORTS-1:0] req_i,
   input  logic                gnt_i,
   output logic                valid_o,
   output logic                lock_o,
   output logic [PORT_W-1:0]   idx_o
);
   localparam logic [PORT_W-1:0] LAST = PORT_W'(NR_PORTS - 1);

   logic [PORT_W-1:0] ptr_q, ptr_d, lock_idx_q, lock_idx_d, cand;
   logic              lock_q, lock_d;

   // Scan from farthest to nearest so the requester closest to the pointer wins.
   always_comb begin
      valid_o = 1'b0;
      idx_o   = ptr_q;
      cand    = '0;
      if (lock_q) begin
         valid_o = req_i[lock_idx_q];
         idx_o   = lock_idx_q;
      end else begin
         for (int unsigned k = 0; k < NR_PORTS; k++) begin
            cand    = PORT_W'((int'(ptr_q) + NR_PORTS - 1 - k) % NR_PORTS);
            idx_o   = req_i[cand] ? cand : idx_o;
            valid_o = valid_o | req_i[cand];
         end
      end
   end

   // Pointer and lock next-state.
   always_comb begin
      lock_d     = valid_o && !gnt_i;
      lock_idx_d = idx_o;
      ptr_d      = ptr_q;
      if (valid_o && gnt_i) begin
         ptr_d = (idx_o == LAST) ? '0 : idx_o + PORT_W'(1);
      end else begin
         ptr_d = ptr_q;
      end
   end

   // Arbiter state registers.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         ptr_q      <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
      end else begin
         ptr_q      <= ptr_d;
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
      end
   end

   assign lock_o = lock_q;
endmodule

// File: rtl/snitch_icache_lookup_arbiter.sv
// Shares one icache lookup stage among NR_PORTS requesters: round-robin request
// arbitration with ID extension, response demux and flush sequencing.
module snitch_icache_lookup_arbiter
   import snitch_icache_lookup_arbiter_pkg::*;
#(
   parameter int unsigned NR_PORTS        = 2,
   parameter int unsigned FETCH_AW        = 32,
   parameter int unsigned ID_WIDTH        = 4,
   parameter int unsigned LINE_WIDTH      = 128,
   parameter int unsigned SET_ALIGN       = 1,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic                               flush_valid_i,
   output logic                               flush_ready_o,
   input  logic [NR_PORTS-1:0][FETCH_AW-1:0]  req_addr_i,
   input  logic [NR_PORTS-1:0][ID_WIDTH-1:0]  req_id_i,
   input  logic [NR_PORTS-1:0]                req_valid_i,
   output logic [NR_PORTS-1:0]                req_ready_o,
   output logic [FETCH_AW-1:0]                rsp_addr_o,
   output logic [ID_WIDTH-1:0]                rsp_id_o,
   output logic [SET_ALIGN-1:0]               rsp_set_o,
   output logic                               rsp_hit_o,
   output logic [LINE_WIDTH-1:0]              rsp_data_o,
   output logic                               rsp_error_o,
   output logic [NR_PORTS-1:0]                rsp_valid_o,
   input  logic [NR_PORTS-1:0]                rsp_ready_i,
   snitch_icache_lookup_arbiter_if.master     lkp
);
   localparam int unsigned       PORT_W  = port_width(NR_PORTS);
   localparam int unsigned       CNT_W   = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_OUTSTANDING);

   flush_state_e        state_q, state_d;
   logic [CNT_W-1:0]    out_cnt_q, out_cnt_d;
   logic                gnt_en, arb_valid, arb_lock, req_hs, rsp_hs;
   logic [PORT_W-1:0]   arb_idx, rsp_port;
   logic [NR_PORTS-1:0] arb_req;

   // A locked grant is finished even if a flush or the limit would block new ones.
   assign gnt_en  = arb_lock || ((state_q == ST_IDLE) && (out_cnt_q < CNT_MAX));
   assign arb_req = req_valid_i & {NR_PORTS{gnt_en}};
   assign req_hs  = lkp.valid && lkp.ready;
   assign rsp_hs  = lkp.rsp_valid && lkp.rsp_ready;
   assign rsp_port = lkp.rsp_id[ID_WIDTH+PORT_W-1 -: PORT_W];

   snitch_icache_lookup_arbiter_rr #(
      .NR_PORTS (NR_PORTS),
      .PORT_W   (PORT_W)
   ) i_rr (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .req_i   (arb_req),
      .gnt_i   (lkp.ready),
      .valid_o (arb_valid),
      .lock_o  (arb_lock),
      .idx_o   (arb_idx)
   );

   // Request path: selected requester onto the lookup port, index prepended to its ID.
   always_comb begin
      lkp.valid   = arb_valid;
      lkp.addr    = '0;
      lkp.id      = '0;
      req_ready_o = '0;
      if (arb_valid) begin
         lkp.addr             = req_addr_i[arb_idx];
         lkp.id               = {arb_idx, req_id_i[arb_idx]};
         req_ready_o[arb_idx] = lkp.ready;
      end else begin
         req_ready_o = '0;
      end
   end

   // Response demux on the ID MSBs.
   always_comb begin
      rsp_valid_o   = '0;
      lkp.rsp_ready = 1'b0;
      for (int unsigned i = 0; i < NR_PORTS; i++) begin
         rsp_valid_o[i] = lkp.rsp_valid && (rsp_port == PORT_W'(i));
         lkp.rsp_ready  = lkp.rsp_ready | (rsp_ready_i[i] && (rsp_port == PORT_W'(i)));
      end
   end

   assign rsp_addr_o      = lkp.rsp_addr;
   assign rsp_id_o        = lkp.rsp_id[ID_WIDTH-1:0];
   assign rsp_set_o       = lkp.rsp_set;
   assign rsp_hit_o       = lkp.rsp_hit;
   assign rsp_data_o      = lkp.rsp_data;
   assign rsp_error_o     = lkp.rsp_error;
   assign lkp.flush_valid = (state_q == ST_FLUSH);
   assign flush_ready_o   = (state_q == ST_DONE);

   // Outstanding counter, saturating at both ends.
   always_comb begin
      out_cnt_d = out_cnt_q;
      if (req_hs && !rsp_hs && (out_cnt_q != CNT_MAX)) begin
         out_cnt_d = out_cnt_q + CNT_W'(1);
      end else if (rsp_hs && !req_hs && (out_cnt_q != '0)) begin
         out_cnt_d = out_cnt_q - CNT_W'(1);
      end else begin
         out_cnt_d = out_cnt_q;
      end
   end

   // Flush sequencer; DRAIN waits until nothing is in flight or being presented.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  state_d = flush_valid_i ? ST_DRAIN : ST_IDLE;
         ST_DRAIN: state_d = ((out_cnt_q == '0) && !lkp.valid) ? ST_FLUSH : ST_DRAIN;
         ST_FLUSH: state_d = lkp.flush_ready ? ST_DONE : ST_FLUSH;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // State and counter registers.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         out_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         out_cnt_q <= out_cnt_d;
      end
   end

   snitch_icache_lookup_arbiter_chk #(
      .NR_PORTS (NR_PORTS),
      .PORT_W   (PORT_W)
   ) i_chk (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .rsp_hs_i    (rsp_hs),
      .cnt_zero_i  (out_cnt_q == '0),
      .rsp_valid_i (lkp.rsp_valid),
      .rsp_port_i  (rsp_port)
   );
endmodule

// File: doc/snitch_icache_lookup_arbiter.md
# snitch_icache_lookup_arbiter

Shares one icache lookup pipeline (tag + data stage, single request port, single flush port) among `NR_PORTS` requesters (L0 handlers, prefetcher). Round-robin arbitrates lookup requests, extends IDs with the requester index, and routes lookup responses back to the originating port. Sequences flushes: blocks new grants, drains outstanding lookups, then forwards the flush to the lookup. Sits between the per-core fetch handlers and the lookup stage.

## Interface
- `NR_PORTS`, 2: number of requesters, ≥1.
- `FETCH_AW`, 32: fetch address width.
- `ID_WIDTH`, 4: per-requester ID width.
- `LINE_WIDTH`, 128: cache line width.
- `SET_ALIGN`, 1: set index width.
- `MAX_OUTSTANDING`, 4: max lookups in flight, ≥1.
- Derived `PORT_W = max(1, $clog2(NR_PORTS))`; lookup ID width `ID_WIDTH+PORT_W`, port index in MSBs.

Ports:
- `clk_i` in 1: clock, the only clock.
- `rst_ni` in 1: synchronous, active-low reset.
- `flush_valid_i` / `flush_ready_o` in/out 1: flush request / one-cycle completion pulse.
- `req_addr_i` in `[NR_PORTS][FETCH_AW]`, `req_id_i` in `[NR_PORTS][ID_WIDTH]`, `req_valid_i` in `[NR_PORTS]`, `req_ready_o` out `[NR_PORTS]`: requester side.
- `rsp_addr_o` out FETCH_AW, `rsp_id_o` out ID_WIDTH, `rsp_set_o` out SET_ALIGN, `rsp_hit_o` out 1, `rsp_data_o` out LINE_WIDTH, `rsp_error_o` out 1: broadcast response payload.
- `rsp_valid_o` out `[NR_PORTS]`, `rsp_ready_i` in `[NR_PORTS]`: per-port response handshake.
- `lkp_addr_o` out FETCH_AW, `lkp_id_o` out ID_WIDTH+PORT_W, `lkp_valid_o` out 1, `lkp_ready_i` in 1: lookup request.
- `lkp_rsp_addr_i`, `lkp_rsp_id_i`, `lkp_rsp_set_i`, `lkp_rsp_hit_i`, `lkp_rsp_data_i`, `lkp_rsp_error_i`, `lkp_rsp_valid_i` in; `lkp_rsp_ready_o` out 1: lookup response.
- `lkp_flush_valid_o` out 1, `lkp_flush_ready_i` in 1: lookup flush.

## Operation
- Grant enable `gnt_en = (state == IDLE) && (out_cnt_q < MAX_OUTSTANDING)`. If deasserted, `lkp_valid_o = 0` and all `req_ready_o = 0`.
- Round-robin selection with lock-in: once `lkp_valid_o` is asserted and not accepted, the selected port, address, and ID stay stable until handshake. Priority pointer moves to granted+1 (mod NR_PORTS) only on `lkp_valid_o && lkp_ready_i`.
- `req_ready_o[g] = lkp_ready_i && gnt_en` for granted port `g`; other ports get 0. `lkp_id_o = {g, req_id_i[g]}`.
- `out_cnt_q` (width `$clog2(MAX_OUTSTANDING+1)`):
  - +1 on request handshake.
  - −1 on response handshake.
  - Unchanged when both occur in the same cycle.
  - Never wraps.
  - A response with count 0 is a protocol error (assertion).
- Response routing:
  - `p = lkp_rsp_id_i[MSBs]`.
  - `rsp_valid_o[p] = lkp_rsp_valid_i`, others 0.
  - `lkp_rsp_ready_o = rsp_ready_i[p]`.
  - Payload passed through, with ID LSBs stripped.
  - `p ≥ NR_PORTS` is illegal (assertion).
- Flush FSM:
  - IDLE → DRAIN when `flush_valid_i`.
  - DRAIN → FLUSH when `out_cnt_q == 0` and there is no request handshake in that cycle. A request already presented still completes, because lock-in is honoured before blocking.
  - FLUSH: `lkp_flush_valid_o = 1`. On `lkp_flush_ready_i` → DONE.
  - DONE: `flush_ready_o = 1` for one cycle → IDLE.
  - `flush_valid_i` arriving during DRAIN, FLUSH or DONE is absorbed into the current flush.
  - Responses keep draining in all states.

## Timing
- Request path is combinational (0-cycle) from `req_*` to `lkp_*`. Response path is combinational from `lkp_rsp_*` to `rsp_*`. No internal buffering.
- Only the pointer, count, FSM state and lock-in state are registered.
- Reset (`rst_ni = 0` at a clock edge):
  - State IDLE, count 0, pointer 0, lock cleared.
  - All outputs 0 after that edge. `rsp_*` payload follows its inputs.
- Reset mid-flush or with lookups in flight abandons them. The lookup is reset with the same `rst_ni`.
- Flush latency with 0 outstanding and `lkp_flush_ready_i = 1`: `flush_valid_i` at cycle 0, DRAIN at 1, FLUSH at 2, `flush_ready_o` at 3.

## Structure
- Add a lookup request typedef (addr, id) and a lookup response typedef (addr, id, set, hit, data, error) to `snitch_icache_pkg`, parameterised via `config_t`. Add the FSM state enum there as well.
- One natural sub-module: `rr_arb_tree` (common_cells), `LockIn = 1`, `ExtPrio = 0`. Its `flush_i` is tied 0 and its request inputs are gated by `gnt_en`.
- Counter, FSM and response demux stay in this module.

## Test plan
- **Round-robin fairness:** ports 0 and 1 valid continuously, `lkp_ready_i = 1` → grant order 0,1,0,1; `lkp_id_o` MSB alternates.
- **Lock-in:** port 1 valid at addr 0x1000, `lkp_ready_i = 0` for 3 cycles, port 0 raises valid meanwhile → addr 0x1000 and ID held stable; port 1 handshakes first.
- **Outstanding limit:** `MAX_OUTSTANDING = 4`, no responses, 6 requests → exactly 4 accepted, `lkp_valid_o = 0` afterwards. A response and a new request in the same cycle → count stays 4.
- **Response routing:** response with `lkp_rsp_id_i = {1, 4'h5}`, `rsp_ready_i = 2'b01` → `rsp_valid_o = 2'b10`, `rsp_id_o = 5`, `lkp_rsp_ready_o = 0` until `rsp_ready_i[1]` goes high.
- **Flush with 2 outstanding:** → no new grants; `lkp_flush_valid_o` rises the cycle after the count reaches 0; `flush_ready_o` pulses one cycle after `lkp_flush_ready_i`; grants resume the next cycle.
- **Reset during FLUSH:** → next cycle all outputs 0, state IDLE; a new request is granted on the following cycle.
